// File: rtl/riscv_bp_pkg.sv
// Shared branch-predictor definitions: 2-bit counter encodings and PC slicing helpers.
package riscv_bp_pkg;

    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] CTR_RESET = CTR_WNT;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

    // Callers cast the result down to their IDX_W / TAG_W width.
    function automatic logic [31:0] pc_idx(input logic [31:0] pc);
        return pc >> 2;
    endfunction

    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state: count up on taken, down on not-taken, clamp at the ends.
module bp_sat_counter
    import riscv_bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational next-PC lookup, registered update from EX.
module branch_target_predictor
    import riscv_bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 32 - IDX_W - 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    output logic [15:0] mispredict_cnt
);

    logic [ENTRIES-1:0] vld_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];
    logic [15:0]        cnt_q;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;
    logic [1:0]       up_ctr_next;
    logic             mispredict;

    assign lk_idx = IDX_W'(pc_idx(PC));
    assign lk_tag = TAG_W'(pc_tag(PC, IDX_W));
    assign up_idx = IDX_W'(pc_idx(upd_pc));
    assign up_tag = TAG_W'(pc_tag(upd_pc, IDX_W));

    // Lookup reads current state only; a same-cycle update becomes visible next cycle.
    assign lk_hit      = vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_hit    = lk_hit;
    assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
    assign pred_target = lk_hit ? tgt_q[lk_idx] : PC + 32'd4;

    assign up_hit = vld_q[up_idx] && (tag_q[up_idx] == up_tag);

    bp_sat_counter u_sat (
        .ctr      (ctr_q[up_idx]),
        .taken    (upd_taken),
        .ctr_next (up_ctr_next)
    );

    // A taken/taken prediction still counts as wrong if a hit entry held a stale target.
    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && upd_pred_taken && up_hit && (tgt_q[up_idx] != upd_target)));

    // upd_valid is a one-cycle strobe with no backpressure: when high at an edge, upd_* are consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= CTR_RESET;
            end
            cnt_q <= '0;
        end else begin
            if (upd_valid) begin
                if (up_hit) begin
                    ctr_q[up_idx] <= up_ctr_next;
                    if (upd_taken) tgt_q[up_idx] <= upd_target;
                end else if (upd_taken) begin
                    vld_q[up_idx] <= 1'b1;
                    tag_q[up_idx] <= up_tag;
                    tgt_q[up_idx] <= upd_target;
                    ctr_q[up_idx] <= CTR_ALLOC;
                end
            end
            if (mispredict) cnt_q <= cnt_q + 16'd1;
        end
    end

    assign mispredict_cnt = cnt_q;

endmodule
